// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and baud divider helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;
`endif

  // Truncating division: clocks per oversample tick.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-clock tick every DIV clocks; i_clr restarts the period.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1
// with an even-parity check and a live parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  logic [1:0]  r_sync;
  logic        r_rx_prev;
  uart_state_e r_state, w_state_d;
  logic [3:0]  r_tick_cnt, w_tick_cnt_d;
  logic [2:0]  r_bit_cnt, w_bit_cnt_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        r_done_ok, w_done_ok;
  logic        r_done_ferr, w_done_ferr;
  logic [7:0]  r_dout;
  logic        r_rdy, r_frame_err, r_overrun;
  logic        w_rx, w_fall, w_tick, w_baud_clr, w_centre;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bad, w_par_bad_d;
  logic        r_done_perr, w_done_perr;
  logic        r_parity_err;
`endif

  assign w_rx     = r_sync[1];
  assign w_fall   = r_rx_prev & ~w_rx;
  assign w_centre = w_tick && (r_tick_cnt == 4'd15);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .i_clk  (clk_50m),
    .i_rst  (rst),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_d    = r_state;
    w_tick_cnt_d = r_tick_cnt;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_done_ok    = 1'b0;
    w_done_ferr  = 1'b0;
    w_baud_clr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_d  = r_par_bad;
    w_done_perr  = 1'b0;
`endif
    if (w_tick && r_state != StIdle) begin
      w_tick_cnt_d = r_tick_cnt + 4'd1;
    end
    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_d    = StStart;
          w_tick_cnt_d = 4'd0;
          w_baud_clr   = 1'b1;
        end
      end
      StStart: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (w_tick && r_tick_cnt == 4'd7) begin
          w_tick_cnt_d = 4'd0;
          w_bit_cnt_d  = 3'd0;
          w_state_d    = w_rx ? StIdle : StData;
        end
      end
      StData: begin
        if (w_centre) begin
          w_shift_d   = {w_rx, r_shift[7:1]};
          w_bit_cnt_d = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_centre) begin
          w_par_bad_d = w_rx ^ (^r_shift);
          w_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (w_centre) begin
          w_state_d = StIdle;
          if (!w_rx) begin
            w_done_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_bad) begin
            w_done_perr = 1'b1;
`endif
          end else begin
            w_done_ok = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_state     <= StIdle;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_done_ok   <= 1'b0;
      r_done_ferr <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx};
      r_rx_prev   <= w_rx;
      r_state     <= w_state_d;
      r_tick_cnt  <= w_tick_cnt_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_done_ok   <= w_done_ok;
      r_done_ferr <= w_done_ferr;
    end
  end

  // Completion beats a coincident rdy_clr so the fresh byte is never lost.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_dout      <= 8'd0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (rdy_clr) begin
        r_rdy       <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (r_done_ok) begin
        if (!r_rdy || rdy_clr) begin
          r_dout <= r_shift;
          r_rdy  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (r_done_ferr) begin
        r_frame_err <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_par_bad    <= 1'b0;
      r_done_perr  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad   <= w_par_bad_d;
      r_done_perr <= w_done_perr;
      if (rdy_clr) begin
        r_parity_err <= 1'b0;
      end
      if (r_done_perr) begin
        r_parity_err <= 1'b1;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = r_dout;
  assign rdy       = r_rdy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (432 clocks per bit); parity steps
// run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT = 432;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  uart_rx dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx         (rx),
    .rdy_clr    (rdy_clr),
    .dout       (dout),
    .rdy        (rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Start bit, data LSB first and (when enabled) the parity bit; stop bit left to caller.
  task automatic send_head(input logic [7:0] data, input logic par);
    rx = 1'b0;
    ticks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      ticks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    ticks(BIT);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
  endtask

  task automatic send_stop(input logic s);
    rx = s;
    ticks(BIT);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] data);
    send_head(data, ^data);
    send_stop(1'b1);
  endtask

  task automatic clr_pulse();
    rdy_clr = 1'b1;
    ticks(1);
    rdy_clr = 1'b0;
    ticks(1);
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    ticks(5);
    chk8("reset_dout", dout, 8'h00);
    chk1("reset_rdy", rdy, 1'b0);
    chk1("reset_frame_err", frame_err, 1'b0);
    chk1("reset_overrun", overrun, 1'b0);
    chk1("reset_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    ticks(20);

    // 0x55: stop sampled 218 clocks into the stop bit, rdy one clock later.
    send_head(8'h55, 1'b0);
    rx = 1'b1;
    ticks(219);
    chk1("rdy_before_latency", rdy, 1'b0);
    ticks(1);
    chk1("rdy_after_latency", rdy, 1'b1);
    chk8("dout_55", dout, 8'h55);
    chk1("frame_err_55", frame_err, 1'b0);
    ticks(BIT - 220);
    clr_pulse();
    chk1("rdy_cleared", rdy, 1'b0);

    // Framing error keeps the old byte.
    send_head(8'hA3, 1'b0);
    send_stop(1'b0);
    ticks(BIT);
    chk1("ferr_rdy", rdy, 1'b0);
    chk1("ferr_set", frame_err, 1'b1);
    chk8("ferr_dout_held", dout, 8'h55);
    clr_pulse();
    chk1("ferr_cleared", frame_err, 1'b0);

    // Back-to-back bytes without acknowledge: second one dropped.
    send_byte(8'h01);
    send_byte(8'h02);
    ticks(20);
    chk8("ovr_dout", dout, 8'h01);
    chk1("ovr_set", overrun, 1'b1);
    chk1("ovr_rdy", rdy, 1'b1);
    clr_pulse();
    chk1("ovr_rdy_clr", rdy, 1'b0);
    chk1("ovr_cleared", overrun, 1'b0);

    // Short low pulse rejected at the start-bit centre.
    rx = 1'b0;
    ticks(100);
    rx = 1'b1;
    ticks(BIT * 12);
    chk1("glitch_no_rdy", rdy, 1'b0);
    send_byte(8'h3C);
    ticks(20);
    chk8("after_glitch_dout", dout, 8'h3C);
    chk1("after_glitch_rdy", rdy, 1'b1);

    // Reset during data bit 4.
    rx = 1'b0;
    ticks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      ticks(BIT);
    end
    rx = 1'b0;
    ticks(200);
    rst = 1'b1;
    ticks(3);
    chk8("midrst_dout", dout, 8'h00);
    chk1("midrst_rdy", rdy, 1'b0);
    chk1("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    ticks(BIT * 2);
    send_byte(8'hFF);
    ticks(20);
    chk8("postrst_dout", dout, 8'hFF);
    chk1("postrst_rdy", rdy, 1'b1);

    // rdy_clr coinciding with completion: new byte wins, no overrun.
    send_head(8'h5A, 1'b0);
    rx = 1'b1;
    ticks(219);
    rdy_clr = 1'b1;
    ticks(1);
    rdy_clr = 1'b0;
    ticks(BIT - 220);
    chk8("coinc_dout", dout, 8'h5A);
    chk1("coinc_rdy", rdy, 1'b1);
    chk1("coinc_overrun", overrun, 1'b0);
    clr_pulse();

    // Break: one framing error, no re-trigger while the line stays low.
    rx = 1'b0;
    ticks(BIT * 11);
    chk1("break_ferr", frame_err, 1'b1);
    chk1("break_rdy", rdy, 1'b0);
    clr_pulse();
    ticks(BIT * 11);
    chk1("break_no_retrigger", frame_err, 1'b0);
    rx = 1'b1;
    ticks(BIT);
    send_byte(8'h81);
    ticks(20);
    chk8("after_break_dout", dout, 8'h81);
    chk1("after_break_rdy", rdy, 1'b1);
    clr_pulse();

`ifdef UART_RX_PARITY_EN
    send_head(8'h07, 1'b0);
    send_stop(1'b1);
    ticks(20);
    chk1("par_bad_err", parity_err, 1'b1);
    chk1("par_bad_rdy", rdy, 1'b0);
    clr_pulse();
    chk1("par_err_cleared", parity_err, 1'b0);
    send_head(8'h07, 1'b1);
    send_stop(1'b1);
    ticks(20);
    chk8("par_ok_dout", dout, 8'h07);
    chk1("par_ok_rdy", rdy, 1'b1);
    chk1("par_ok_err", parity_err, 1'b0);
`else
    chk1("parity_err_tied", parity_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
